// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, legality check, arbiter FSM states
// and the captured-operation record. Imported by the ALU, the arbiter top and
// the decoder.
package alu_pkg;

    typedef enum logic [4:0] {
        ADD  = 5'd1,
        SUB  = 5'd2,
        SLL  = 5'd3,
        SRL  = 5'd4,
        SRA  = 5'd5,
        EQ   = 5'd6,
        SLT  = 5'd7,
        ADDU = 5'd8,
        XOR  = 5'd9,
        OR   = 5'd10,
        AND  = 5'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [4:0]  func;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    function automatic logic is_legal_op(input logic [4:0] f);
        return (f >= 5'd1) && (f <= 5'd11);
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU.
// Ports: alu_function (op code), operand_a/operand_b, result, result_equal_zero.
// Shifts use the full 32-bit operand_b: amounts of 32 or more give 0 (SLL/SRL)
// or the sign fill (SRA). Unknown codes return 0.
module alu
    import alu_pkg::*;
(
    input  logic [4:0]  alu_function,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] result,
    output logic        result_equal_zero
);

    always_comb begin
        result = '0;
        case (alu_function)
            ADD, ADDU: result = operand_a + operand_b;
            SUB:       result = operand_a - operand_b;
            SLL:       result = operand_a << operand_b;
            SRL:       result = operand_a >> operand_b;
            SRA:       result = $signed(operand_a) >>> operand_b;
            EQ:        result = {31'd0, operand_a == operand_b};
            SLT:       result = {31'd0, $signed(operand_a) < $signed(operand_b)};
            XOR:       result = operand_a ^ operand_b;
            OR:        result = operand_a | operand_b;
            AND:       result = operand_a & operand_b;
            default:   result = '0;
        endcase
    end

    assign result_equal_zero = (result == 32'd0);

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Ports: req (requests), ptr (highest-priority index), en (grant enable),
// gnt (one-hot grant, zero when disabled or idle), idx (encoded grant).
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        // Scan ptr, ptr+1, ... wrapping; first requester found wins.
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (en && !found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among N_REQ requesters with round-robin arbitration.
// Ports: req_valid/req_ready/req_func/req_a/req_b per requester (payload packed
// per lane); rsp_valid/rsp_ready handshake with rsp_id, rsp_result, rsp_zero,
// rsp_illegal; op_count counts accepted responses and wraps.
// Flow: IDLE -(grant)-> EXEC -> RESP -(rsp_ready, grant)-> EXEC, so one op per
// two cycles when the consumer never stalls.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter  int N_REQ = 2,
    parameter  int CNT_W = 16,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0][4:0]   req_func,
    input  logic [N_REQ-1:0][31:0]  req_a,
    input  logic [N_REQ-1:0][31:0]  req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    rsp_zero,
    output logic                    rsp_illegal,
    output logic [CNT_W-1:0]        op_count
);

    arb_state_e       state, state_nxt;
    logic [ID_W-1:0]  ptr;
    alu_req_t         cap;
    logic [ID_W-1:0]  cap_id;
    logic             accept_en;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             take;
    logic [31:0]      alu_res;
    logic             alu_zero;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .en  (accept_en),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign take      = |gnt;
    assign req_ready = gnt;
    assign rsp_valid = (state == ST_RESP);

    // ALU sees only the captured operands, never the live request ports.
    alu u_alu (
        .alu_function      (cap.func),
        .operand_a         (cap.a),
        .operand_b         (cap.b),
        .result            (alu_res),
        .result_equal_zero (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept_en = 1'b0;
        case (state)
            ST_IDLE: begin
                accept_en = 1'b1;
                if (|req_valid) state_nxt = ST_EXEC;
            end
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    accept_en = 1'b1;
                    state_nxt = (|req_valid) ? ST_EXEC : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Keep req_ready low while reset is held, not just after it.
        accept_en = accept_en & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            cap         <= '0;
            cap_id      <= '0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            if (take) begin
                ptr      <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                cap.func <= req_func[gnt_idx];
                cap.a    <= req_a[gnt_idx];
                cap.b    <= req_b[gnt_idx];
                cap_id   <= gnt_idx;
            end
            if (state == ST_EXEC) begin
                rsp_id      <= cap_id;
                rsp_result  <= is_legal_op(cap.func) ? alu_res : 32'd0;
                rsp_zero    <= is_legal_op(cap.func) ? alu_zero : 1'b1;
                rsp_illegal <= !is_legal_op(cap.func);
            end
            if (rsp_valid && rsp_ready) op_count <= op_count + 1'b1;
        end
    end

endmodule
